// File: rtl/matmul_sched.sv
// Round-robin job scheduler for an external matrix multiplier: arbitrates requesters,
// streams A then B operands to the multiplier, forwards results and reports completion/timeout.
module matmul_sched #(
    parameter int DATA_WIDTH = 16,
    parameter int M          = 4,
    parameter int N          = 2,
    parameter int K          = 3,
    parameter int NREQ       = 2,
    parameter int TIMEOUT    = 256
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NREQ-1:0]                     req,
    output logic [NREQ-1:0]                     gnt,
    output logic                                op_rd_en,
    output logic                                op_rd_is_b,
    output logic [$clog2((M > K) ? M : K)-1:0]  op_rd_row,
    output logic [$clog2((K > N) ? K : N)-1:0]  op_rd_col,
    output logic [$clog2(NREQ)-1:0]             op_rd_id,
    input  logic [DATA_WIDTH-1:0]               op_rd_data,
    output logic                                mm_start,
    output logic [DATA_WIDTH-1:0]               mm_a_data,
    output logic [$clog2(M)-1:0]                mm_a_row,
    output logic [$clog2(K)-1:0]                mm_a_col,
    output logic                                mm_a_valid,
    output logic [DATA_WIDTH-1:0]               mm_b_data,
    output logic [$clog2(K)-1:0]                mm_b_row,
    output logic [$clog2(N)-1:0]                mm_b_col,
    output logic                                mm_b_valid,
    input  logic [DATA_WIDTH-1:0]               mm_c_data,
    input  logic [$clog2(M)-1:0]                mm_c_row,
    input  logic [$clog2(N)-1:0]                mm_c_col,
    input  logic                                mm_c_valid,
    input  logic                                mm_done,
    output logic                                res_valid,
    output logic [$clog2(NREQ)-1:0]             res_id,
    output logic [$clog2(M)-1:0]                res_row,
    output logic [$clog2(N)-1:0]                res_col,
    output logic [DATA_WIDTH-1:0]               res_data,
    output logic                                job_done,
    output logic                                job_err,
    output logic [$clog2(NREQ)-1:0]             job_id
);
    localparam int RW = $clog2((M > K) ? M : K);
    localparam int CW = $clog2((K > N) ? K : N);
    localparam int IW = $clog2(NREQ);
    localparam int AR = $clog2(M);
    localparam int AC = $clog2(K);
    localparam int BR = $clog2(K);
    localparam int BC = $clog2(N);
    localparam int TW = $clog2(TIMEOUT);

    // state | meaning
    // IDLE  | arbitrate among pending requests
    // START | pulse mm_start, grant visible
    // LOAD_A| stream M*K A operands row-major
    // LOAD_B| stream K*N B operands row-major
    // WAIT  | wait for mm_done or timeout
    // FIN   | report job_done / job_err, release grant
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_LOAD_A = 3'd2;
    localparam logic [2:0] S_LOAD_B = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_FIN    = 3'd5;

    localparam logic [RW-1:0] A_LAST_ROW = RW'(M - 1);
    localparam logic [CW-1:0] A_LAST_COL = CW'(K - 1);
    localparam logic [RW-1:0] B_LAST_ROW = RW'(K - 1);
    localparam logic [CW-1:0] B_LAST_COL = CW'(N - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    logic [2:0]    state;
    logic [IW-1:0] last;
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;
    logic [RW-1:0] rd_row;
    logic [CW-1:0] rd_col;
    logic [TW-1:0] timer;
    logic          err;
    logic          fwd;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last) + i) % NREQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign fwd = (state == S_LOAD_A) || (state == S_LOAD_B) || (state == S_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            last       <= IW'(NREQ - 1);
            idx        <= '0;
            gnt        <= '0;
            rd_row     <= '0;
            rd_col     <= '0;
            timer      <= '0;
            err        <= 1'b0;
            mm_a_valid <= 1'b0;
            mm_a_row   <= '0;
            mm_a_col   <= '0;
            mm_b_valid <= 1'b0;
            mm_b_row   <= '0;
            mm_b_col   <= '0;
            res_valid  <= 1'b0;
            res_id     <= '0;
            res_row    <= '0;
            res_col    <= '0;
            res_data   <= '0;
        end else begin
            mm_a_valid <= (state == S_LOAD_A);
            mm_b_valid <= (state == S_LOAD_B);
            if (state == S_LOAD_A) begin
                mm_a_row <= rd_row[AR-1:0];
                mm_a_col <= rd_col[AC-1:0];
            end
            if (state == S_LOAD_B) begin
                mm_b_row <= rd_row[BR-1:0];
                mm_b_col <= rd_col[BC-1:0];
            end
            res_valid <= mm_c_valid && fwd;
            if (mm_c_valid && fwd) begin
                res_id   <= idx;
                res_row  <= mm_c_row;
                res_col  <= mm_c_col;
                res_data <= mm_c_data;
            end
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= ONE_HOT0 << pick;
                        idx   <= pick;
                        last  <= pick;
                        state <= S_START;
                    end
                end
                S_START: begin
                    rd_row <= '0;
                    rd_col <= '0;
                    err    <= 1'b0;
                    state  <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    if (rd_col == A_LAST_COL) begin
                        rd_col <= '0;
                        if (rd_row == A_LAST_ROW) begin
                            rd_row <= '0;
                            state  <= S_LOAD_B;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
                S_LOAD_B: begin
                    if (rd_col == B_LAST_COL) begin
                        rd_col <= '0;
                        if (rd_row == B_LAST_ROW) begin
                            rd_row <= '0;
                            timer  <= '0;
                            state  <= S_WAIT;
                        end else begin
                            rd_row <= rd_row + 1'b1;
                        end
                    end else begin
                        rd_col <= rd_col + 1'b1;
                    end
                end
                S_WAIT: begin
                    // mm_done wins over a timeout landing in the same cycle
                    if (mm_done) begin
                        state <= S_FIN;
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        state <= S_FIN;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_FIN: begin
                    gnt   <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign op_rd_en   = (state == S_LOAD_A) || (state == S_LOAD_B);
    assign op_rd_is_b = (state == S_LOAD_B);
    assign op_rd_row  = rd_row;
    assign op_rd_col  = rd_col;
    assign op_rd_id   = op_rd_en ? idx : '0;
    assign mm_start   = (state == S_START);
    assign mm_a_data  = mm_a_valid ? op_rd_data : '0;
    assign mm_b_data  = mm_b_valid ? op_rd_data : '0;
    assign job_done   = (state == S_FIN) && !err;
    assign job_err    = (state == S_FIN) && err;
    assign job_id     = (state == S_FIN) ? idx : '0;
endmodule

// File: tb/tb_matmul_sched.sv
// Directed bench for matmul_sched: operand memory and multiplier models, event monitor,
// and hand-computed expectations for single job, contention, timeout, reset abort and stray traffic.
module tb_matmul_sched;
    localparam int TO = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        op_rd_en, op_rd_is_b;
    logic [1:0]  op_rd_row, op_rd_col;
    logic        op_rd_id;
    logic [15:0] op_rd_data = '0;
    logic        mm_start;
    logic [15:0] mm_a_data, mm_b_data;
    logic [1:0]  mm_a_row, mm_a_col, mm_b_row;
    logic        mm_b_col, mm_a_valid, mm_b_valid;
    logic [15:0] mm_c_data;
    logic [1:0]  mm_c_row;
    logic        mm_c_col, mm_c_valid, mm_done;
    logic        res_valid, res_id, res_col;
    logic [1:0]  res_row;
    logic [15:0] res_data;
    logic        job_done, job_err, job_id;

    matmul_sched dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt),
        .op_rd_en(op_rd_en), .op_rd_is_b(op_rd_is_b), .op_rd_row(op_rd_row),
        .op_rd_col(op_rd_col), .op_rd_id(op_rd_id), .op_rd_data(op_rd_data),
        .mm_start(mm_start),
        .mm_a_data(mm_a_data), .mm_a_row(mm_a_row), .mm_a_col(mm_a_col), .mm_a_valid(mm_a_valid),
        .mm_b_data(mm_b_data), .mm_b_row(mm_b_row), .mm_b_col(mm_b_col), .mm_b_valid(mm_b_valid),
        .mm_c_data(mm_c_data), .mm_c_row(mm_c_row), .mm_c_col(mm_c_col), .mm_c_valid(mm_c_valid),
        .mm_done(mm_done),
        .res_valid(res_valid), .res_id(res_id), .res_row(res_row), .res_col(res_col),
        .res_data(res_data), .job_done(job_done), .job_err(job_err), .job_id(job_id)
    );

    always #5 clk = ~clk;

    logic [15:0] amem [4][4];
    logic [15:0] bmem [4][2];

    always @(posedge clk)
        if (op_rd_en)
            op_rd_data <= op_rd_is_b ? bmem[op_rd_row][op_rd_col[0]] : amem[op_rd_row][op_rd_col];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Multiplier model: captures streamed operands, emits C in Q8.8 row-major, then mm_done.
    logic hang = 1'b0;
    int   stray_req = 0;
    initial begin : mult_model
        logic [15:0] ca [4][4];
        logic [15:0] cb [4][2];
        logic [31:0] acc;
        int nops, emit, r, c, stray_done;
        nops = 0; emit = -1; stray_done = 0;
        mm_c_valid = 0; mm_done = 0; mm_c_data = 0; mm_c_row = 0; mm_c_col = 0;
        forever begin
            @(posedge clk); #1;
            mm_c_valid = 0; mm_done = 0; mm_c_data = 0; mm_c_row = 0; mm_c_col = 0;
            if (rst || mm_start) begin
                nops = 0;
                emit = -1;
            end else begin
                if (emit >= 0 && emit < 8) begin
                    r = emit / 2;
                    c = emit % 2;
                    acc = 0;
                    for (int kk = 0; kk < 3; kk++)
                        acc = acc + 32'(ca[r][kk]) * 32'(cb[kk][c]);
                    mm_c_valid = 1;
                    mm_c_data  = acc[23:8];
                    mm_c_row   = r[1:0];
                    mm_c_col   = c[0];
                    emit++;
                end else if (emit == 8) begin
                    mm_done = 1;
                    emit = -1;
                end
                if (mm_a_valid) begin
                    ca[mm_a_row][mm_a_col] = mm_a_data;
                    nops++;
                end
                if (mm_b_valid) begin
                    cb[mm_b_row][mm_b_col] = mm_b_data;
                    nops++;
                    if (nops == 18 && !hang) emit = 0;
                end
            end
            if (stray_done != stray_req) begin
                mm_c_valid = 1;
                mm_c_data  = 16'hDEAD;
                stray_done++;
            end
        end
    end

    int          cyc = 0;
    int          rd_n = 0, res_n = 0, st_n = 0, done_n = 0, err_n = 0;
    int          bad_gnt = 0, both_ab = 0, both_job = 0;
    int          last_op_cyc = 0, err_cyc = 0;
    logic        done_id;
    logic [4:0]  rd_log  [1024];
    logic [19:0] res_log [256];
    logic [1:0]  st_gnt  [64];
    int          st_cyc  [64];
    int          done_cyc[64];

    initial begin : monitor
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (mm_a_valid && mm_b_valid) both_ab++;
            if (gnt == 2'b11) bad_gnt++;
            if (op_rd_en) begin
                rd_log[rd_n] = {op_rd_is_b, op_rd_row, op_rd_col};
                rd_n++;
            end
            if (mm_a_valid || mm_b_valid) last_op_cyc = cyc;
            if (mm_start) begin
                st_gnt[st_n] = gnt;
                st_cyc[st_n] = cyc;
                st_n++;
            end
            if (res_valid) begin
                res_log[res_n] = {res_id, res_row, res_col, res_data};
                res_n++;
            end
            if (job_done) begin
                done_cyc[done_n] = cyc;
                done_id = job_id;
                done_n++;
            end
            if (job_err) begin
                err_cyc = cyc;
                err_n++;
            end
            if (job_done && job_err) both_job++;
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        rst = 1; req = 0;
        tick(); tick();
        rst = 0;
    endtask

    task automatic wait_jobs(input string tag, input int base, input int cnt, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done_n + err_n >= base + cnt) break;
            tick();
        end
        chk(tag, done_n + err_n, base + cnt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctl"}, {gnt, op_rd_en, op_rd_is_b, mm_start, mm_a_valid, mm_b_valid,
                            res_valid, job_done, job_err}, 0);
        chk({tag, "_fields"}, {op_rd_row, op_rd_col, op_rd_id, mm_a_row, mm_a_col, mm_b_row,
                               mm_b_col, res_id, res_row, res_col, job_id}, 0);
        chk({tag, "_data"}, {mm_a_data, mm_b_data, res_data}, 0);
    endtask

    logic [15:0] exp_c [8] = '{16'h0400, 16'h0500, 16'h0A00, 16'h0B00,
                               16'h1000, 16'h1100, 16'h0300, 16'h0200};
    logic [3:0]  a_vals [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 1, 0, 2};
    logic [3:0]  b_vals [6]  = '{1, 0, 0, 1, 1, 1};

    initial begin : main
        int c0, rb, resb, db, eb, sb;
        for (int i = 0; i < 16; i++) amem[i/4][i%4] = 16'h0;
        for (int i = 0; i < 8; i++)  bmem[i/2][i%2] = 16'h0;
        for (int i = 0; i < 12; i++) amem[i/3][i%3] = {4'h0, a_vals[i], 8'h00};
        for (int i = 0; i < 6; i++)  bmem[i/2][i%2] = {4'h0, b_vals[i], 8'h00};

        // reset state
        do_reset();
        check_all_zero("reset");

        // single job, requester 0
        tick();
        req = 2'b01;
        c0 = cyc; rb = rd_n; resb = res_n; db = done_n; eb = err_n;
        chk("gnt_cycle0", gnt, 2'b00);
        tick();
        chk("gnt_cycle1", gnt, 2'b01);
        chk("start_cycle1", mm_start, 1);
        wait_jobs("job1_wait", db + eb, 1, 200);
        req = 0;
        chk("job1_reads", rd_n - rb, 18);
        for (int i = 0; i < 18; i++) begin
            logic [4:0] e;
            if (i < 12) e = {1'b0, 2'(i / 3), 2'(i % 3)};
            else        e = {1'b1, 2'((i - 12) / 2), 2'((i - 12) % 2)};
            chk($sformatf("job1_rd%0d", i), rd_log[rb + i], e);
        end
        chk("job1_latency", last_op_cyc - c0, 20);
        chk("job1_results", res_n - resb, 8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("job1_res%0d", i), res_log[resb + i], {1'b0, 2'(i / 2), 1'(i % 2), exp_c[i]});
        chk("job1_done", done_n - db, 1);
        chk("job1_err", err_n - eb, 0);
        chk("job1_id", done_id, 0);

        // contention, both requesting from reset
        do_reset();
        req = 2'b11;
        db = done_n; eb = err_n; sb = st_n;
        wait_jobs("rr_wait", db + eb, 3, 400);
        req = 0;
        chk("rr_grant0", st_gnt[sb], 2'b01);
        chk("rr_grant1", st_gnt[sb + 1], 2'b10);
        chk("rr_grant2", st_gnt[sb + 2], 2'b01);
        chk("rr_gap", st_cyc[sb + 1] - done_cyc[db], 2);
        chk("rr_onehot", bad_gnt, 0);
        chk("rr_ab_excl", both_ab, 0);

        // timeout
        do_reset();
        hang = 1;
        tick();
        req = 2'b01;
        db = done_n; eb = err_n;
        tick(); tick();
        req = 0;
        wait_jobs("to_wait", db + eb, 1, 400);
        chk("to_err", err_n - eb, 1);
        chk("to_nodone", done_n - db, 0);
        chk("to_latency", err_cyc - last_op_cyc, TO);
        chk("to_both", both_job, 0);
        tick();
        chk("to_idle_gnt", gnt, 2'b00);
        hang = 0;

        // reset mid LOAD_A
        do_reset();
        tick();
        req = 2'b01;
        db = done_n; eb = err_n;
        repeat (5) tick();
        chk("mr_in_load_a", op_rd_en, 1);
        rst = 1; req = 0;
        tick();
        check_all_zero("midrst");
        tick();
        rst = 0;
        tick();
        chk("mr_no_pulse", (done_n - db) + (err_n - eb), 0);
        req = 2'b01;
        rb = rd_n;
        wait_jobs("mr_wait", db + eb, 1, 200);
        req = 0;
        chk("mr_first_rd", rd_log[rb], 5'b0_00_00);
        chk("mr_done", done_n - db, 1);

        // stray traffic
        do_reset();
        tick();
        resb = res_n; sb = st_n;
        stray_req++;
        tick(); tick(); tick();
        chk("stray_res", res_n - resb, 0);
        chk("stray_nogrant", st_n - sb, 0);
        req = 2'b01;
        db = done_n; eb = err_n;
        repeat (15) tick();
        chk("drop_in_load_b", op_rd_is_b, 1);
        req = 0;
        wait_jobs("drop_wait", db + eb, 1, 200);
        chk("drop_done", done_n - db, 1);
        chk("drop_results", res_n - resb, 8);
        repeat (3) tick();
        chk("drop_noregrant", st_n - sb, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/matmul_sched.md
MATMUL_SCHED -- requirements
Module: matmul_sched

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_WIDTH, 16, operand/result width
- M, 4, rows of A and C
- N, 2, columns of B and C
- K, 3, inner dimension
- NREQ, 2, number of requesters
- TIMEOUT, 256, cycles allowed from the last operand to mm_done
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- req  in  NREQ  job request, level, one bit per requester
- gnt  out  NREQ  one-hot grant, held for the whole job
- op_rd_en  out  1  operand read strobe
- op_rd_is_b  out  1  0 = read A, 1 = read B
- op_rd_row  out  $clog2(max(M,K))  operand row
- op_rd_col  out  $clog2(max(K,N))  operand column
- op_rd_id  out  $clog2(NREQ)  requester that owns the operand
- op_rd_data  in  DATA_WIDTH  read data, valid 1 cycle after op_rd_en
- mm_start  out  1  start pulse to the multiplier
- mm_a_data/row/col/valid  out  DATA_WIDTH/$clog2(M)/$clog2(K)/1  A element stream
- mm_b_data/row/col/valid  out  DATA_WIDTH/$clog2(K)/$clog2(N)/1  B element stream
- mm_c_data/row/col/valid  in  DATA_WIDTH/$clog2(M)/$clog2(N)/1  result stream
- mm_done  in  1  multiplier complete
- res_valid/id/row/col/data  out  1/$clog2(NREQ)/$clog2(M)/$clog2(N)/DATA_WIDTH  forwarded result
- job_done  out  1  1-cycle completion pulse
- job_err  out  1  1-cycle timeout pulse
- job_id  out  $clog2(NREQ)  requester for job_done/job_err

Function
REQ-003 FSM states SHALL be IDLE, START, LOAD_A, LOAD_B, WAIT, FIN.
REQ-004 IDLE: if any req bit is high, grant exactly one requester by round-robin and go to START on the next cycle.
REQ-005 Round-robin: search starts at (last granted + 1) mod NREQ; after reset, requester 0 has highest priority.
REQ-006 START: mm_start = 1 for exactly 1 cycle; gnt is registered and visible in this same cycle; next state is LOAD_A.
REQ-007 LOAD_A: issue M*K reads with op_rd_is_b = 0, one per cycle, row-major (row outer, column inner); then go to LOAD_B.
REQ-008 LOAD_B: issue K*N reads with op_rd_is_b = 1, row-major; then go to WAIT.
REQ-009 For a read issued in cycle t, mm_a_valid or mm_b_valid SHALL be 1 in cycle t+1, carrying op_rd_data and the row/col registered from cycle t.
REQ-010 Only one of mm_a_valid and mm_b_valid SHALL ever be high in a cycle.
REQ-011 Result forwarding, in LOAD_A, LOAD_B and WAIT: when mm_c_valid = 1 in cycle t, res_valid = 1 in cycle t+1 with the registered c fields and res_id = granted index.
REQ-012 mm_c_valid in IDLE, START or FIN SHALL be ignored.
REQ-013 WAIT: on mm_done = 1, go to FIN.
REQ-014 WAIT timeout: the counter starts at 0 on WAIT entry; if it reaches TIMEOUT-1 without mm_done, go to FIN with an error flag.
REQ-015 FIN, 1 cycle: job_done = 1 (or job_err = 1 if timed out, never both) and job_id = grant index; gnt clears at the FIN->IDLE transition.
REQ-016 req changes during a job SHALL be ignored; arbitration happens only in IDLE.
REQ-017 Total latency, req rising in IDLE (cycle 0) to last operand valid: 2 + M*K + K*N cycles (20 cycles at defaults).
REQ-018 A requester still requesting in FIN may be regranted only after returning to IDLE; back-to-back jobs are separated by at least 1 IDLE cycle.

Reset
REQ-019 While rst = 1 at a clk edge, the block SHALL enter IDLE, set the RR pointer so requester 0 wins, clear counters, and drive every output to 0.
REQ-020 rst mid-job SHALL abort the job with no job_done or job_err pulse; the first grant after rst deasserts is evaluated in IDLE.

Verification
REQ-021 Single job: req = 01 held, multiplier model with A = [[1,2,3],[4,5,6],[7,8,9],[1,0,2]] and B = [[1,0],[0,1],[1,1]] in Q8.8 -> gnt = 01 at cycle 1; 18 reads in order; res values 4,5,10,11,16,17,3,2 (as 0x0400 etc.) with res_id = 0; one job_done with job_id = 0.
REQ-022 Contention: req = 11 from reset -> requester 0 served first, then requester 1, then requester 0; gnt never has 2 bits set.
REQ-023 Timeout: mm_done never asserted -> job_err is exactly TIMEOUT cycles after WAIT entry, no job_done, then return to IDLE.
REQ-024 Reset mid-LOAD_A (cycle 5) -> next cycle all outputs 0, no job pulse; a fresh req restarts the read sequence from A[0][0].
REQ-025 Stray traffic: mm_c_valid pulsed in IDLE -> res_valid stays 0; req dropped during LOAD_B -> the job still completes with job_done.
